// File: rtl/mod7_residue_gen.sv
// Serial mod-7 residue generator: folds a WIDTH-bit operand one 3-bit chunk per
// cycle with end-around carry (8 == 1 mod 7), then presents a normalized residue.
module mod7_residue_gen #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [2:0]       o_out_res
);
    localparam int NCH = (WIDTH + 2) / 3;
    localparam int EW  = 3 * NCH;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [EW-1:0] r_shift;
    logic [2:0]    r_acc;
    logic [CW-1:0] r_cnt;

    logic [EW-1:0] w_ext;
    logic [3:0]    w_sum;
    logic          w_last;
    logic          w_accept;

    // Top chunk is zero-padded when WIDTH is not a multiple of 3.
    always_comb begin
        w_ext              = '0;
        w_ext[WIDTH-1:0]   = i_in_data;
    end

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_shift[2:0]};
    assign w_last     = (r_cnt == CW'(NCH - 1));
    assign o_in_ready = (r_state == S_IDLE) && !i_rst;
    assign w_accept   = i_in_valid && o_in_ready;
    assign o_out_valid = (r_state == S_DONE);
    // 3'b111 is the alternate encoding of zero.
    assign o_out_res  = (r_acc == 3'b111) ? 3'b000 : r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= w_ext;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // Max sum 14 folds to 6+1=7, so the carry add never overflows 3 bits.
                    r_acc   <= w_sum[2:0] + {2'b00, w_sum[3]};
                    r_shift <= r_shift >> 3;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod7_residue_gen.sv
// Directed bench for mod7_residue_gen: vector table, exhaustive 12-bit sweep,
// backpressure and mid-operation reset sequences.
module tb_mod7_residue_gen;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_res;

    int nerr = 0;
    int nchk = 0;

    mod7_residue_gen #(.WIDTH(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_res   (out_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers d, waits for the residue (out_ready=1), returns it and the cycle
    // index at which out_valid appeared (accept cycle = 0).
    task automatic do_op(input logic [15:0] d, output logic [2:0] res,
                         output int lat, output bit ok);
        int w;
        ok  = 1'b1;
        lat = 0;
        res = 3'b000;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            ok = 1'b0;
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        ok  = out_valid;
        res = out_res;
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        logic [2:0] r;
        int lat;
        bit ok;
        bit seen;

        vecs[0] = '{16'd100,   3'd2};
        vecs[1] = '{16'd49,    3'd0};
        vecs[2] = '{16'd7,     3'd0};
        vecs[3] = '{16'd0,     3'd0};
        vecs[4] = '{16'hFFFF,  3'd1};
        vecs[5] = '{16'd1000,  3'd6};
        vecs[6] = '{16'd13,    3'd6};
        vecs[7] = '{16'd8,     3'd1};
        vecs[8] = '{16'h8000,  3'd1};
        vecs[9] = '{16'd12345, 3'd4};

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;

        // Reset behaviour
        tick();
        chk("rst_out_valid_c1", 32'(out_valid), 32'd0);
        chk("rst_in_ready_c1",  32'(in_ready),  32'd0);
        tick();
        chk("rst_out_valid_c2", 32'(out_valid), 32'd0);
        chk("rst_in_ready_c2",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_res",  32'(out_res),  32'd0);
        tick();

        // Table-driven vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].data, r, lat, ok);
            chk($sformatf("vec%0d_valid", i), 32'(ok), 32'd1);
            chk($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd7);
            chk($sformatf("vec%0d_pulse", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_ready_after", i), 32'(in_ready), 32'd1);
        end

        // Exhaustive 12-bit sweep
        for (int v = 0; v < 4096; v++) begin
            do_op(16'(v), r, lat, ok);
            chk($sformatf("sweep_%0d", v), {28'd0, ok, r}, {28'd0, 1'b1, 3'(v % 7)});
        end

        // Backpressure: residue held, second operand waits for IDLE
        in_valid  = 1'b1;
        in_data   = 16'd1000;
        out_ready = 1'b0;
        tick();
        in_data = 16'd13;
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("bp_valid_arrives", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_res_%0d", k),   32'(out_res),   32'd6);
            chk($sformatf("bp_hold_ready_%0d", k), 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_no_same_cycle_accept", 32'(in_ready), 32'd0);
        tick();
        chk("bp_bubble_valid", 32'(out_valid), 32'd0);
        chk("bp_bubble_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_res",   32'(out_res),   32'd6);
        tick();

        // Mid-operation reset
        in_valid  = 1'b1;
        in_data   = 16'd500;
        out_ready = 1'b1;
        while (!in_ready) tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        do_op(16'd13, r, lat, ok);
        chk("midrst_next_valid", 32'(ok), 32'd1);
        chk("midrst_next_res",   32'(r),  32'd6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
